alu_issue_stage: RTL

- Registered issue stage directly upstream of the 64-bit ALU.
- Takes decoded instruction fields and register-file read data, and generates the 4-bit ALU operation code from ALUOp/funct3/funct7.
- Selects operand B (rs2 or immediate) and presents a, b and ALU op to the ALU through a valid/ready handshake.
- Contains a 2-entry skid buffer, so in_ready is a pure register output and backpressure never drops an instruction.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_control.sv | 43 ++++
 rtl/alu_issue_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage: operand widths, the 4-bit ALU
// control codes, the main-decoder ALUOp classes and the packed entry that is
// held in the issue stage's main and skid registers.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int XLEN = 64;
   localparam int RD_W = 5;

   // ALU control codes understood by the downstream ALU.
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Main-decoder ALUOp classes.
   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_RSVD   = 2'b11;

   // One instruction as presented to the ALU.
   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [3:0]      aluop;
      logic [RD_W-1:0] rd;
      logic            reg_write;
      logic            illegal;
   } issue_entry_t;

endpackage

// File: rtl/alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
// Purely combinational ALU control decode: maps main-decoder ALUOp plus
// funct3/funct7[5] onto the 4-bit ALU code, flagging unsupported combinations.
//
// Ports:
//   alu_op2_i  - main-decoder ALUOp class
//   funct3_i   - instruction funct3
//   funct7_5_i - instruction bit 30
//   aluop_o    - 4-bit ALU control code (ADD for illegal combinations)
//   illegal_o  - 1 when the combination is not supported
// -----------------------------------------------------------------------------
module alu_control
   import alu_pkg::*;
(
   input  logic [1:0] alu_op2_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   output logic [3:0] aluop_o,
   output logic       illegal_o
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs (no latches).
      aluop_o   = ALU_ADD;
      illegal_o = 1'b0;
      unique case (alu_op2_i)
         ALUOP_MEM:    aluop_o = ALU_ADD;
         ALUOP_BRANCH: aluop_o = ALU_SUB;
         ALUOP_RTYPE: begin
            unique case (funct3_i)
               3'b000:  aluop_o = funct7_5_i ? ALU_SUB : ALU_ADD;
               3'b111:  aluop_o = ALU_AND;
               3'b110:  aluop_o = ALU_OR;
               default: illegal_o = 1'b1;
            endcase
         end
         ALUOP_RSVD:   illegal_o = 1'b1;
         default:      illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Registered issue stage in front of the 64-bit ALU. Captures decoded fields
// and register-file data, decodes the ALU control code, selects operand B and
// presents the entry to the ALU over a valid/ready handshake. A main register
// drives the outputs and a skid register absorbs the one extra entry that may
// arrive while in_ready (a pure register output) is still high.
//
// Ports:
//   clk, rst_n       - clock (rising edge), synchronous active-low reset
//   flush            - discard all held entries and the same-cycle input
//   in_valid/ready   - upstream handshake; in_ready is registered
//   in_rs1_data      - operand a
//   in_rs2_data      - operand b when in_alu_src=0
//   in_imm           - operand b when in_alu_src=1
//   in_alu_op2       - main-decoder ALUOp
//   in_funct3        - funct3
//   in_funct7_5      - instruction bit 30
//   in_rd            - destination register
//   in_reg_write     - writeback enable
//   out_valid/ready  - downstream handshake
//   out_a, out_b     - ALU operands
//   out_aluop        - ALU control code
//   out_rd           - forwarded rd
//   out_reg_write    - forwarded writeback enable (0 when illegal)
//   out_illegal      - unsupported op combination
//
// XLEN/RD_W must match alu_pkg, since the held entry type comes from there.
// -----------------------------------------------------------------------------
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = alu_pkg::XLEN,
   parameter int RD_W = alu_pkg::RD_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_alu_src,
   input  logic [1:0]      in_alu_op2,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_5,
   input  logic [RD_W-1:0] in_rd,
   input  logic            in_reg_write,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [3:0]      out_aluop,
   output logic [RD_W-1:0] out_rd,
   output logic            out_reg_write,
   output logic            out_illegal
);

   issue_entry_t main_q, main_d;
   issue_entry_t skid_q, skid_d;
   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic         in_ready_q, in_ready_d;

   logic         accept;
   logic         drain_ok;
   logic [3:0]   ctrl_aluop;
   logic         ctrl_illegal;
   issue_entry_t new_entry;

   // Single decoder shared by both storage registers: decode happens at capture.
   alu_control u_alu_control (
      .alu_op2_i  (in_alu_op2),
      .funct3_i   (in_funct3),
      .funct7_5_i (in_funct7_5),
      .aluop_o    (ctrl_aluop),
      .illegal_o  (ctrl_illegal)
   );

   always_comb begin
      new_entry.a         = in_rs1_data;
      new_entry.b         = in_alu_src ? in_imm : in_rs2_data;
      new_entry.aluop     = ctrl_aluop;
      new_entry.rd        = in_rd;
      new_entry.reg_write = in_reg_write & ~ctrl_illegal;
      new_entry.illegal   = ctrl_illegal;
   end

   assign accept   = in_valid & in_ready_q;
   // Main can take a new value when empty or when its entry leaves this cycle.
   assign drain_ok = ~main_valid_q | out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;

      if (flush) begin
         // Data is left as is; only validity matters once flushed.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (drain_ok) begin
         if (skid_valid_q) begin
            // Oldest entry moves forward; in_ready_q was 0 so accept is 0 here.
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = accept;
            if (accept) skid_d = new_entry;
         end else begin
            main_valid_d = accept;
            if (accept) main_d = new_entry;
         end
      end else if (accept) begin
         skid_d       = new_entry;
         skid_valid_d = 1'b1;
      end

      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the two data registers are reset too, because outputs must read 0 after reset.
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = main_valid_q;
   assign out_a         = main_q.a;
   assign out_b         = main_q.b;
   assign out_aluop     = main_q.aluop;
   assign out_rd        = main_q.rd;
   assign out_reg_write = main_q.reg_write;
   assign out_illegal   = main_q.illegal;

endmodule
